// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings and types for the instruction fetch unit and its PC target calculator.
package instr_fetch_unit_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned STATUS_W = 4;
   localparam int unsigned K_W      = 26;

   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_INC  = 2'b01;
   localparam logic [1:0] PC_REL  = 2'b10;
   localparam logic [1:0] PC_REG  = 2'b11;

   localparam logic OFF_B  = 1'b0;
   localparam logic OFF_CB = 1'b1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic [1:0]     op;
      logic           off_sel;
      logic [K_W-1:0] k;
   } pc_cmd_t;

endpackage

// File: rtl/instr_fetch_unit_pc_target_calc.sv
// Combinational next-PC selection: hold, +4, PC-relative branch target, or register load.
module pc_target_calc
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] fetched_pc,
   input  logic [1:0]        op,
   input  logic              off_sel,
   input  logic [K_W-1:0]    k,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] next_pc_c
);

   localparam logic [ADDR_W-1:0] INC4     = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] rel_target;

   // B uses a 26-bit word offset, CBZ/B.cond a 19-bit one; both relative to the fetched instruction
   always_comb begin
      offset = '0;
      if (off_sel == OFF_CB) offset = ADDR_W'($signed(k[18:0]));
      else                   offset = ADDR_W'($signed(k[25:0]));
      rel_target = fetched_pc + (offset << 2);
   end

   always_comb begin
      next_pc_c = pc;
      case (op)
         PC_HOLD: next_pc_c = pc;
         PC_INC:  next_pc_c = pc + INC4;
         PC_REL:  next_pc_c = rel_target;
         PC_REG:  next_pc_c = load_val & ALIGN_MASK;
         default: next_pc_c = pc;
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem read handshake, latches IR, and holds NZCV status.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter bit                AUTO_INC = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                fetch_req,
   input  logic                pc_update,
   input  logic [1:0]          pc_op,
   input  logic                off_sel,
   input  logic [INSTR_W-1:0]  k,
   input  logic [ADDR_W-1:0]   pc_load_val,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  IR,
   output logic                ir_valid,
   output logic                busy,
   output logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W-1:0]   fetched_pc,
   input  logic [STATUS_W-1:0] status_in,
   input  logic                status_load,
   output logic [STATUS_W-1:0] status
);

   localparam logic [ADDR_W-1:0] INC4 = ADDR_W'(4);

   logic [1:0]          state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d, fetched_pc_q, fetched_pc_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic                imem_req_q, imem_req_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic                ir_valid_q, ir_valid_d;
   logic                busy_q, busy_d;
   logic [STATUS_W-1:0] status_q, status_d;
   logic                pend_valid_q, pend_valid_d;
   pc_cmd_t             pend_cmd_q, pend_cmd_d;
   logic [ADDR_W-1:0]   pend_load_q, pend_load_d;
   logic [ADDR_W-1:0]   imm_next_pc, pend_next_pc;
   logic                unused_k_hi;

   assign unused_k_hi = ^k[INSTR_W-1:K_W];

   pc_target_calc #(.ADDR_W(ADDR_W)) u_imm_calc (
      .pc         (pc_q),
      .fetched_pc (fetched_pc_q),
      .op         (pc_op),
      .off_sel    (off_sel),
      .k          (k[K_W-1:0]),
      .load_val   (pc_load_val),
      .next_pc_c  (imm_next_pc)
   );

   pc_target_calc #(.ADDR_W(ADDR_W)) u_pend_calc (
      .pc         (pc_q),
      .fetched_pc (fetched_pc_q),
      .op         (pend_cmd_q.op),
      .off_sel    (pend_cmd_q.off_sel),
      .k          (pend_cmd_q.k),
      .load_val   (pend_load_q),
      .next_pc_c  (pend_next_pc)
   );

   // Next-state and datapath; an update arriving mid-fetch is parked until the fetch retires
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetched_pc_d = fetched_pc_q;
      imem_addr_d  = imem_addr_q;
      imem_req_d   = imem_req_q;
      ir_d         = ir_q;
      ir_valid_d   = 1'b0;
      pend_valid_d = pend_valid_q;
      pend_cmd_d   = pend_cmd_q;
      pend_load_d  = pend_load_q;
      status_d     = status_load ? status_in : status_q;

      if (pc_update && state_q != ST_IDLE) begin
         pend_valid_d = 1'b1;
         pend_cmd_d   = '{op: pc_op, off_sel: off_sel, k: k[K_W-1:0]};
         pend_load_d  = pc_load_val;
      end

      case (state_q)
         ST_IDLE: begin
            if (pc_update) pc_d = imm_next_pc;
            if (fetch_req) begin
               state_d     = ST_REQ;
               imem_req_d  = 1'b1;
               imem_addr_d = pc_update ? imm_next_pc : pc_q;
            end
         end
         ST_REQ: begin
            if (imem_ack) begin
               state_d      = ST_DONE;
               imem_req_d   = 1'b0;
               ir_d         = imem_rdata;
               fetched_pc_d = imem_addr_q;
               ir_valid_d   = 1'b1;
               if (AUTO_INC) pc_d = imem_addr_q + INC4;
            end
         end
         ST_DONE: begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
            if (pc_update)         pc_d = imm_next_pc;
            else if (pend_valid_q) pc_d = pend_next_pc;
         end
         default: begin
            state_d    = ST_IDLE;
            imem_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         fetched_pc_q <= RESET_PC;
         imem_addr_q  <= RESET_PC;
         imem_req_q   <= 1'b0;
         ir_q         <= '0;
         ir_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         status_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_cmd_q   <= '0;
         pend_load_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetched_pc_q <= fetched_pc_d;
         imem_addr_q  <= imem_addr_d;
         imem_req_q   <= imem_req_d;
         ir_q         <= ir_d;
         ir_valid_q   <= ir_valid_d;
         busy_q       <= busy_d;
         status_q     <= status_d;
         pend_valid_q <= pend_valid_d;
         pend_cmd_q   <= pend_cmd_d;
         pend_load_q  <= pend_load_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = imem_addr_q;
   assign IR         = ir_q;
   assign ir_valid   = ir_valid_q;
   assign busy       = busy_q;
   assign pc         = pc_q;
   assign fetched_pc = fetched_pc_q;
   assign status     = status_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC-update vector table plus hand-written fetch sequences.
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_req = 1'b0;
   logic        pc_update = 1'b0;
   logic [1:0]  pc_op = 2'b00;
   logic        off_sel = 1'b0;
   logic [31:0] k = '0;
   logic [63:0] pc_load_val = '0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] IR;
   logic        ir_valid;
   logic        busy;
   logic [63:0] pc;
   logic [63:0] fetched_pc;
   logic [3:0]  status_in = '0;
   logic        status_load = 1'b0;
   logic [3:0]  status;

   int n_cmp = 0;
   int n_err = 0;

   instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .AUTO_INC(1'b1)) dut (
      .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc_update(pc_update),
      .pc_op(pc_op), .off_sel(off_sel), .k(k), .pc_load_val(pc_load_val),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .IR(IR), .ir_valid(ir_valid), .busy(busy),
      .pc(pc), .fetched_pc(fetched_pc), .status_in(status_in),
      .status_load(status_load), .status(status)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  op;
      logic        sel;
      logic [31:0] kv;
      logic [63:0] lv;
      logic [63:0] exp_pc;
   } vec_t;

   vec_t vecs[13];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_upd(input logic [1:0] op, input logic sel, input logic [31:0] kv,
                          input logic [63:0] lv);
      pc_update = 1'b1; pc_op = op; off_sel = sel; k = kv; pc_load_val = lv;
   endtask

   // Full fetch from IDLE with a given number of wait cycles before ack
   task automatic do_fetch(input logic [63:0] exp_addr, input int waits,
                           input logic [31:0] data, input logic [63:0] exp_pc);
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         chk("req_high", 64'(imem_req), 64'h1);
         chk("req_addr", imem_addr, exp_addr);
         chk("no_valid_in_req", 64'(ir_valid), 64'h0);
         if (i == waits) begin
            imem_ack = 1'b1;
            imem_rdata = data;
         end
         step();
      end
      imem_ack = 1'b0;
      chk("done_valid", 64'(ir_valid), 64'h1);
      chk("done_ir", 64'(IR), 64'(data));
      chk("done_fetched_pc", fetched_pc, exp_addr);
      chk("done_pc", pc, exp_pc);
      chk("done_req_low", 64'(imem_req), 64'h0);
      step();
      chk("idle_valid_low", 64'(ir_valid), 64'h0);
      chk("idle_not_busy", 64'(busy), 64'h0);
   endtask

   initial begin
      vecs[0]  = '{2'b11, 1'b0, 32'h0,        64'h4003,                64'h4000};
      vecs[1]  = '{2'b01, 1'b0, 32'h0,        64'h0,                   64'h4004};
      vecs[2]  = '{2'b00, 1'b0, 32'h0,        64'h0,                   64'h4004};
      vecs[3]  = '{2'b10, 1'b0, 32'h1,        64'h0,                   64'h4};
      vecs[4]  = '{2'b10, 1'b0, 32'h03FFFFFE, 64'h0,                   64'hFFFF_FFFF_FFFF_FFF8};
      vecs[5]  = '{2'b10, 1'b1, 32'h0007FFFF, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFC};
      vecs[6]  = '{2'b10, 1'b1, 32'h00040000, 64'h0,                   64'hFFFF_FFFF_FFF0_0000};
      vecs[7]  = '{2'b10, 1'b0, 32'h02000000, 64'h0,                   64'hFFFF_FFFF_F800_0000};
      vecs[8]  = '{2'b10, 1'b1, 32'h00080001, 64'h0,                   64'h4};
      vecs[9]  = '{2'b10, 1'b0, 32'hFC000003, 64'h0,                   64'hC};
      vecs[10] = '{2'b01, 1'b0, 32'h0,        64'h0,                   64'h10};
      vecs[11] = '{2'b11, 1'b0, 32'h0,        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC};
      vecs[12] = '{2'b01, 1'b0, 32'h0,        64'h0,                   64'h0};

      // Reset state
      #2;
      chk("rst_pc", pc, 64'h0);
      chk("rst_fetched_pc", fetched_pc, 64'h0);
      chk("rst_ir", 64'(IR), 64'h0);
      chk("rst_status", 64'(status), 64'h0);
      chk("rst_req", 64'(imem_req), 64'h0);
      chk("rst_valid", 64'(ir_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      step(); step();
      reset = 1'b1;
      step();

      // First fetch, ack on first REQ cycle
      do_fetch(64'h0, 0, 32'h8B020020, 64'h4);

      // IDLE pc updates from fetched_pc=0
      foreach (vecs[i]) begin
         set_upd(vecs[i].op, vecs[i].sel, vecs[i].kv, vecs[i].lv);
         step();
         pc_update = 1'b0;
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      end

      // Wait states
      set_upd(2'b11, 1'b0, 32'h0, 64'h100);
      step();
      pc_update = 1'b0;
      do_fetch(64'h100, 3, 32'h12345678, 64'h104);

      // Backward branches relative to fetched_pc=0x200
      set_upd(2'b11, 1'b0, 32'h0, 64'h200);
      step();
      pc_update = 1'b0;
      do_fetch(64'h200, 0, 32'h14000000, 64'h204);
      set_upd(2'b10, 1'b0, 32'h03FFFFFE, 64'h0);
      step();
      chk("b_back_pc", pc, 64'h1F8);
      set_upd(2'b10, 1'b1, 32'h0007FFFF, 64'h0);
      step();
      pc_update = 1'b0;
      chk("cb_back_pc", pc, 64'h1FC);

      // BR parked during REQ (last wins), status load while busy, fetch_req in DONE ignored
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("br_req_addr", imem_addr, 64'h1FC);
      set_upd(2'b11, 1'b0, 32'h0, 64'h1233);
      status_load = 1'b1; status_in = 4'hA;
      step();
      chk("status_busy", 64'(status), 64'hA);
      chk("br_pc_not_yet", pc, 64'h1FC);
      set_upd(2'b11, 1'b0, 32'h0, 64'h4003);
      status_load = 1'b0; status_in = 4'h5;
      imem_ack = 1'b1; imem_rdata = 32'hD61F0000;
      step();
      pc_update = 1'b0; imem_ack = 1'b0; fetch_req = 1'b1;
      chk("br_done_valid", 64'(ir_valid), 64'h1);
      chk("br_done_autoinc_pc", pc, 64'h200);
      chk("br_done_fetched", fetched_pc, 64'h1FC);
      chk("status_hold", 64'(status), 64'hA);
      step();
      fetch_req = 1'b0;
      chk("br_pending_pc", pc, 64'h4000);
      chk("br_idle_busy", 64'(busy), 64'h0);
      step();
      chk("done_fetch_ignored_busy", 64'(busy), 64'h0);
      chk("done_fetch_ignored_req", 64'(imem_req), 64'h0);

      // Same-cycle update and fetch: fetch uses the updated PC
      set_upd(2'b11, 1'b0, 32'h0, 64'h300);
      fetch_req = 1'b1;
      step();
      pc_update = 1'b0; fetch_req = 1'b0;
      chk("same_cycle_addr", imem_addr, 64'h300);
      imem_ack = 1'b1; imem_rdata = 32'hAABBCCDD;
      step();
      imem_ack = 1'b0;
      chk("same_cycle_pc", pc, 64'h304);
      step();

      // Reset mid-fetch, late ack ignored
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("mid_req_high", 64'(imem_req), 64'h1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_req", 64'(imem_req), 64'h0);
      chk("mid_rst_busy", 64'(busy), 64'h0);
      chk("mid_rst_pc", pc, 64'h0);
      chk("mid_rst_ir", 64'(IR), 64'h0);
      chk("mid_rst_status", 64'(status), 64'h0);
      step();
      reset = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'hFFFFFFFF;
      step();
      imem_ack = 1'b0;
      chk("late_ack_valid", 64'(ir_valid), 64'h0);
      chk("late_ack_ir", 64'(IR), 64'h0);
      chk("late_ack_busy", 64'(busy), 64'h0);
      chk("late_ack_pc", pc, 64'h0);

      // PC wrap on auto-increment
      set_upd(2'b11, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      pc_update = 1'b0;
      do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 1, 32'hCAFEF00D, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
